// File: rtl/wu_memory.sv
// wu_memory: WU instruction store.
// Three-stage read pipeline (SRAM read, output register, FIFO push) feeding a
// valid/ready output FIFO, with credit-based registered stall toward the fetcher
// and a program-load write port.
module wu_memory #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int STALL_FREE = 4
) (
    input  logic                  clk,
    input  logic                  reset_poweron,
    input  logic                  wuf__wum__read,
    input  logic [ADDR_WIDTH-1:0] wuf__wum__addr,
    output logic                  wum__wuf__stall,
    input  logic                  mcntl__wum__write,
    input  logic [ADDR_WIDTH-1:0] mcntl__wum__waddr,
    input  logic [DATA_WIDTH-1:0] mcntl__wum__wdata,
    output logic                  wum__wud__valid,
    output logic [DATA_WIDTH-1:0] wum__wud__data,
    input  logic                  wud__wum__ready,
    output logic                  wum__mcntl__overflow
);

    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam int WORDS = 1 << ADDR_WIDTH;
    localparam logic [CW:0] FREE_MAX   = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW:0] FREE_STALL = (CW+1)'(STALL_FREE);

    logic [DATA_WIDTH-1:0] r_mem [WORDS];

    logic                  r_s0_valid;
    logic [DATA_WIDTH-1:0] r_s0_data;
    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_data;

    logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_stall;
    logic                  r_overflow;
    logic [DATA_WIDTH-1:0] r_data;

    logic [CW:0]           w_free;
    logic [CW:0]           w_free_next;
    logic [CW-1:0]         w_count_next;
    logic                  w_accept;
    logic                  w_drop;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_data_next;

    // Credit accounting, FIFO push/pop and next head word
    always_comb begin
        w_push       = r_s1_valid;
        w_pop        = (r_count != '0) && wud__wum__ready;
        w_free       = FREE_MAX - {1'b0, r_count}
                     - {{CW{1'b0}}, r_s0_valid} - {{CW{1'b0}}, r_s1_valid};
        w_accept     = wuf__wum__read && (w_free != '0);
        w_drop       = wuf__wum__read && (w_free == '0);
        w_count_next = r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
        w_free_next  = FREE_MAX - {1'b0, w_count_next}
                     - {{CW{1'b0}}, w_accept} - {{CW{1'b0}}, r_s0_valid};
        // Head register: follows the next queued word, or the word being
        // pushed when it becomes the only entry; otherwise holds.
        w_data_next  = r_data;
        if (w_pop && (r_count > CW'(1))) begin
            w_data_next = r_fifo[r_rd_ptr + PW'(1)];
        end else if (w_push && (w_count_next == CW'(1))) begin
            w_data_next = r_s1_data;
        end
    end

    // SRAM: write port plus read at the request edge (read-first on collision)
    always_ff @(posedge clk) begin
        if (mcntl__wum__write) begin
            r_mem[mcntl__wum__waddr] <= mcntl__wum__wdata;
        end
        if (w_accept) begin
            r_s0_data <= r_mem[wuf__wum__addr];
        end
    end

    // Read pipeline valids and S1 data register
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            r_s0_valid <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s0_valid <= w_accept;
            r_s1_valid <= r_s0_valid;
            if (r_s0_valid) begin
                r_s1_data <= r_s0_data;
            end
        end
    end

    // Output FIFO storage
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= r_s1_data;
        end
    end

    // FIFO pointers/count, head word, stall and sticky overflow
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_stall    <= 1'b0;
            r_overflow <= 1'b0;
            r_data     <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= w_count_next;
            r_stall <= (w_free_next <= FREE_STALL);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            r_data <= w_data_next;
        end
    end

    assign wum__wuf__stall      = r_stall;
    assign wum__wud__valid      = (r_count != '0);
    assign wum__wud__data       = r_data;
    assign wum__mcntl__overflow = r_overflow;

endmodule

// File: tb/tb_wu_memory.sv
// Testbench for wu_memory: directed vector table, hand sequences for
// back-pressure/overflow/reset, and randomized traffic against a queue model.
module tb_wu_memory;

    localparam int AW = 10;
    localparam int DW = 64;
    localparam int FD = 8;
    localparam int SF = 4;

    logic          clk = 1'b0;
    logic          reset_poweron;
    logic          rd;
    logic [AW-1:0] raddr;
    logic          wr;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          ready;
    logic          stall;
    logic          valid;
    logic [DW-1:0] data;
    logic          ovf;

    wu_memory #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(FD),
        .STALL_FREE(SF)
    ) dut (
        .clk                 (clk),
        .reset_poweron       (reset_poweron),
        .wuf__wum__read      (rd),
        .wuf__wum__addr      (raddr),
        .wum__wuf__stall     (stall),
        .mcntl__wum__write   (wr),
        .mcntl__wum__waddr   (waddr),
        .mcntl__wum__wdata   (wdata),
        .wum__wud__valid     (valid),
        .wum__wud__data      (data),
        .wud__wum__ready     (ready),
        .wum__mcntl__overflow(ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: store contents, words in flight with due cycle, queue.
    typedef struct {
        logic [DW-1:0] w;
        int unsigned   due;
    } pend_t;

    logic [DW-1:0] m_mem [1 << AW];
    logic [DW-1:0] m_fifo [$];
    pend_t         m_pend [$];
    int unsigned   tcyc = 0;
    bit            m_ovf;
    bit            m_stall;
    logic [DW-1:0] m_data;

    logic [DW-1:0] popped [$];
    bit s1, s2, s3;   // stall history seen by the modelled fetcher

    function automatic logic [DW-1:0] pat(input int unsigned a);
        return 64'hA5A5_0000_0000_0000 | 64'(a);
    endfunction

    task automatic check_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_n(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_pend.delete();
        m_ovf   = 1'b0;
        m_stall = 1'b0;
        m_data  = '0;
        s1 = 1'b0;
        s2 = 1'b0;
        s3 = 1'b0;
    endtask

    task automatic model_edge();
        int    free_now;
        int    free_after;
        pend_t p;
        if (!reset_poweron) begin
            model_reset();
            return;
        end
        tcyc++;
        free_now = FD - int'(m_fifo.size()) - int'(m_pend.size());
        if ((m_fifo.size() > 0) && ready) begin
            void'(m_fifo.pop_front());
        end
        while ((m_pend.size() > 0) && (m_pend[0].due == tcyc)) begin
            p = m_pend.pop_front();
            m_fifo.push_back(p.w);
        end
        if (rd) begin
            if (free_now > 0) begin
                p.w   = m_mem[raddr];
                p.due = tcyc + 2;
                m_pend.push_back(p);
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (wr) begin
            m_mem[waddr] = wdata;
        end
        free_after = FD - int'(m_fifo.size()) - int'(m_pend.size());
        m_stall = (free_after <= SF);
        if (m_fifo.size() > 0) begin
            m_data = m_fifo[0];
        end
    endtask

    // One clock: record pop, advance model at the edge, compare at negedge.
    task automatic cycle();
        if (valid && ready && reset_poweron) begin
            popped.push_back(data);
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_b("stall", stall, m_stall);
        check_b("valid", valid, m_fifo.size() > 0);
        check_w("data", data, m_data);
        check_b("overflow", ovf, m_ovf);
        s3 = s2;
        s2 = s1;
        s1 = stall;
    endtask

    task automatic idle_inputs();
        rd    = 1'b0;
        raddr = '0;
        wr    = 1'b0;
        waddr = '0;
        wdata = '0;
    endtask

    task automatic async_reset();
        #2 reset_poweron = 1'b0;
        #1;
        check_b("rst_stall", stall, 1'b0);
        check_b("rst_valid", valid, 1'b0);
        check_b("rst_overflow", ovf, 1'b0);
        check_w("rst_data", data, 64'h0);
        model_reset();
        idle_inputs();
        cycle();
        cycle();
        reset_poweron = 1'b1;
    endtask

    typedef struct {
        logic          rd;
        logic [AW-1:0] ra;
        logic          wr;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          ev;
        logic          cd;
        logic [DW-1:0] ed;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int unsigned   nxt;
        int unsigned   nissued;
        logic [DW-1:0] exp_q [$];

        // Latency of a single read, then the read-first collision on address 3.
        tbl[0] = '{1'b1, 10'd5, 1'b0, 10'd0, 64'h0,  1'b0, 1'b0, 64'h0};
        tbl[1] = '{1'b0, 10'd0, 1'b0, 10'd0, 64'h0,  1'b0, 1'b0, 64'h0};
        tbl[2] = '{1'b0, 10'd0, 1'b0, 10'd0, 64'h0,  1'b1, 1'b1, 64'hA5A5_0000_0000_0005};
        tbl[3] = '{1'b0, 10'd0, 1'b0, 10'd0, 64'h0,  1'b0, 1'b1, 64'hA5A5_0000_0000_0005};
        tbl[4] = '{1'b0, 10'd0, 1'b1, 10'd3, 64'h11, 1'b0, 1'b1, 64'hA5A5_0000_0000_0005};
        tbl[5] = '{1'b1, 10'd3, 1'b1, 10'd3, 64'h22, 1'b0, 1'b0, 64'h0};
        tbl[6] = '{1'b1, 10'd3, 1'b0, 10'd0, 64'h0,  1'b0, 1'b0, 64'h0};
        tbl[7] = '{1'b0, 10'd0, 1'b0, 10'd0, 64'h0,  1'b1, 1'b1, 64'h11};
        tbl[8] = '{1'b0, 10'd0, 1'b0, 10'd0, 64'h0,  1'b1, 1'b1, 64'h22};
        tbl[9] = '{1'b0, 10'd0, 1'b0, 10'd0, 64'h0,  1'b0, 1'b1, 64'h22};

        idle_inputs();
        ready = 1'b0;
        reset_poweron = 1'b0;
        model_reset();
        cycle();
        cycle();
        reset_poweron = 1'b1;
        check_b("reset_stall", stall, 1'b0);
        check_b("reset_valid", valid, 1'b0);
        check_w("reset_data", data, 64'h0);

        // Program load
        for (int unsigned a = 0; a < (1 << AW); a++) begin
            wr    = 1'b1;
            waddr = AW'(a);
            wdata = pat(a);
            cycle();
        end
        idle_inputs();

        // Directed table
        ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rd    = tbl[i].rd;
            raddr = tbl[i].ra;
            wr    = tbl[i].wr;
            waddr = tbl[i].wa;
            wdata = tbl[i].wd;
            cycle();
            check_b($sformatf("vec%0d_valid", i), valid, tbl[i].ev);
            check_b($sformatf("vec%0d_stall", i), stall, 1'b0);
            if (tbl[i].cd) begin
                check_w($sformatf("vec%0d_data", i), data, tbl[i].ed);
            end
        end
        idle_inputs();

        // Back-pressure with a fetcher that sees stall through two registers
        ready = 1'b0;
        nxt   = 100;
        for (int i = 0; i < 20; i++) begin
            rd = !s3;
            raddr = AW'(nxt);
            if (rd) nxt++;
            cycle();
        end
        rd = 1'b0;
        cycle();
        cycle();
        check_b("bp_stall_high", stall, 1'b1);
        check_b("bp_no_overflow", ovf, 1'b0);
        nissued = nxt - 100;
        popped.delete();
        ready = 1'b1;
        repeat (FD + 4) cycle();
        check_n("bp_word_count", popped.size(), int'(nissued));
        for (int i = 0; i < popped.size(); i++) begin
            check_w("bp_word_order", popped[i], pat(100 + i));
        end

        // Overflow: 12 back-to-back reads ignoring stall, decoder not ready
        ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            rd    = 1'b1;
            raddr = AW'(200 + i);
            cycle();
        end
        rd = 1'b0;
        cycle();
        cycle();
        check_b("ovf_set", ovf, 1'b1);
        check_b("ovf_full_valid", valid, 1'b1);
        check_b("ovf_full_stall", stall, 1'b1);

        // Drain a full FIFO while the fetcher keeps reading
        popped.delete();
        exp_q.delete();
        for (int i = 0; i < FD; i++) exp_q.push_back(pat(200 + i));
        ready = 1'b1;
        nxt   = 300;
        s1 = 1'b1;
        s2 = 1'b1;
        s3 = 1'b1;
        for (int i = 0; i < 24; i++) begin
            rd = !s3;
            raddr = AW'(nxt);
            if (rd) begin
                exp_q.push_back(pat(nxt));
                nxt++;
            end
            cycle();
        end
        rd = 1'b0;
        repeat (FD + 6) cycle();
        check_n("fullpp_count", popped.size(), exp_q.size());
        for (int i = 0; i < popped.size() && i < exp_q.size(); i++) begin
            check_w("fullpp_order", popped[i], exp_q[i]);
        end
        check_b("ovf_sticky", ovf, 1'b1);

        // Random traffic ignoring stall, with an async reset mid-burst
        for (int i = 0; i < 300; i++) begin
            rd    = ($urandom_range(0, 3) != 0);
            raddr = AW'($urandom);
            wr    = ($urandom_range(0, 3) == 0);
            waddr = AW'(512 + $urandom_range(0, 511));
            wdata = {$urandom(), $urandom()};
            ready = ($urandom_range(0, 1) == 1);
            cycle();
            if (i == 150) async_reset();
        end
        idle_inputs();
        async_reset();

        // First read after reset returns with two-cycle latency
        ready = 1'b1;
        rd    = 1'b1;
        raddr = 10'd5;
        cycle();
        rd = 1'b0;
        check_b("post_rst_lat1", valid, 1'b0);
        cycle();
        check_b("post_rst_lat2", valid, 1'b0);
        cycle();
        check_b("post_rst_lat3", valid, 1'b1);
        check_w("post_rst_data", data, 64'hA5A5_0000_0000_0005);
        check_b("post_rst_ovf", ovf, 1'b0);

        // Random traffic through the lagged fetcher: never overflows
        for (int i = 0; i < 500; i++) begin
            rd    = ($urandom_range(0, 4) != 0) && !s3;
            raddr = AW'($urandom);
            wr    = ($urandom_range(0, 3) == 0);
            waddr = AW'(512 + $urandom_range(0, 511));
            wdata = {$urandom(), $urandom()};
            ready = ($urandom_range(0, 4) < 2);
            cycle();
        end
        check_b("lag_no_overflow", ovf, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
